// File: rtl/ttni_fault_injector.sv
// TTNI gateway fault injector: one registered valid/ready stage that can
// corrupt a field of selected words. An arm/skip/count sequencer decides
// which accepted words are faulted.
module ttni_fault_injector #(
  parameter int DATA_W    = 34,
  parameter int FIELD_LSB = 28,
  parameter int FIELD_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_en,
  input  logic              cfg_arm,
  input  logic [1:0]        cfg_mode,
  input  logic [FIELD_W-1:0] cfg_value,
  input  logic [CNT_W-1:0]  cfg_skip,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              active,
  output logic              done,
  output logic [CNT_W-1:0]  inj_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_INJECT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] M_PASS  = 2'd0;
  localparam logic [1:0] M_FORCE = 2'd1;
  localparam logic [1:0] M_XOR   = 2'd2;
  localparam logic [1:0] M_DROP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   inj_q, inj_d;
  logic [1:0]         mode_q, mode_d;
  logic [FIELD_W-1:0] value_q, value_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               vld_q, vld_d;

  logic               accept;
  logic               fault_now;
  logic [DATA_W-1:0]  faulted;

  assign in_ready  = !vld_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign active    = (state_q == S_WAIT) | (state_q == S_INJECT);
  assign done      = (state_q == S_DONE);
  assign inj_cnt   = inj_q;

  // A word is faulted only while enabled and the sequencer has run out of skips.
  assign fault_now = cfg_en & accept &
                     (((state_q == S_WAIT) & (skip_q == '0)) | (state_q == S_INJECT));

  // Field corruption using the shadowed mode/value; other bits untouched.
  always_comb begin
    faulted = in_data;
    case (mode_q)
      M_FORCE: faulted[FIELD_LSB +: FIELD_W] = value_q;
      M_XOR:   faulted[FIELD_LSB +: FIELD_W] = in_data[FIELD_LSB +: FIELD_W] ^ value_q;
      default: faulted = in_data;
    endcase
  end

  // Output register: load on acceptance, drain when consumed; drops never assert valid.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (accept) begin
      if (fault_now && (mode_q == M_DROP)) begin
        vld_d = 1'b0;
      end else begin
        vld_d  = 1'b1;
        data_d = fault_now ? faulted : in_data;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Sequencer next-state: disable beats acceptance, acceptance beats arm.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    rem_d   = rem_q;
    inj_d   = inj_q;
    mode_d  = mode_q;
    value_d = value_q;
    if (fault_now && (inj_q != '1)) inj_d = inj_q + 1'b1;
    if (!cfg_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (accept) begin
            if (skip_q != '0) begin
              skip_d = skip_q - 1'b1;
            end else begin
              state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_INJECT;
              if (rem_q != '0) rem_d = rem_q - 1'b1;
            end
          end
        end
        S_INJECT: begin
          if (accept) begin
            if (rem_q == CNT_W'(1)) begin
              state_d = S_DONE;
              rem_d   = '0;
            end else if (rem_q != '0) begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE: acceptance never transitions, so arm applies.
          if (cfg_arm) begin
            state_d = S_WAIT;
            skip_d  = cfg_skip;
            rem_d   = cfg_count;
            inj_d   = '0;
            mode_d  = cfg_mode;
            value_d = cfg_value;
          end
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      rem_q   <= '0;
      inj_q   <= '0;
      mode_q  <= M_PASS;
      value_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      rem_q   <= rem_d;
      inj_q   <= inj_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_ttni_fault_injector.sv
// Scoreboard bench for ttni_fault_injector: the driver pushes expected
// words on acceptance, a negedge monitor pops and compares on each transfer.
module tb_ttni_fault_injector;

  localparam int DATA_W = 34;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_en;
  logic              cfg_arm;
  logic [1:0]        cfg_mode;
  logic [3:0]        cfg_value;
  logic [CNT_W-1:0]  cfg_skip;
  logic [CNT_W-1:0]  cfg_count;
  logic              active;
  logic              done;
  logic [CNT_W-1:0]  inj_cnt;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] expq[$];
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d;

  ttni_fault_injector dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_en(cfg_en), .cfg_arm(cfg_arm), .cfg_mode(cfg_mode),
    .cfg_value(cfg_value), .cfg_skip(cfg_skip), .cfg_count(cfg_count),
    .active(active), .done(done), .inj_cnt(inj_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready here.
  always @(negedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v && out_valid) chk("stall_stable", 64'(out_data), 64'(hold_d));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          chk("out_data", 64'(out_data), 64'(expq.pop_front()));
        end
      end
      hold_v <= out_valid && !out_ready;
      hold_d <= out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic [DATA_W-1:0] d, input bit drop, input logic [DATA_W-1:0] exp);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(n), 64'd0);
    if (!drop) expq.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Shadow regs must ignore config changes after the arm pulse, so scramble them.
  task automatic arm(input logic [1:0] m, input logic [3:0] v,
                     input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] c);
    cfg_mode = m; cfg_value = v; cfg_skip = s; cfg_count = c; cfg_arm = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0;
    cfg_mode = 2'd0; cfg_value = 4'h0; cfg_skip = '0; cfg_count = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] ones;
    logic [3:0] pat;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_en = 1'b0; cfg_arm = 1'b0; cfg_mode = 2'd0; cfg_value = 4'h0;
    cfg_skip = '0; cfg_count = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_inj_cnt", 64'(inj_cnt), 64'd0);

    // 1: disabled, clean pass-through with 1-cycle latency
    send(34'h0, 1'b0, 34'h0);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_data", 64'(out_data), 64'd0);
    for (int i = 1; i < 5; i++) send(34'(i), 1'b0, 34'(i));
    drain();
    chk("t1_inj_cnt", 64'(inj_cnt), 64'd0);
    chk("t1_active", 64'(active), 64'd0);

    // 2: force field=2, skip 2, count 3
    cfg_en = 1'b1;
    arm(2'd1, 4'b0010, 16'd2, 16'd3);
    chk("t2_active", 64'(active), 64'd1);
    ones = 34'h3_FFFF_FFFF;
    for (int i = 0; i < 8; i++)
      send(ones, 1'b0, (i >= 2 && i <= 4) ? 34'h3_2FFF_FFFF : ones);
    drain();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_inj_cnt", 64'(inj_cnt), 64'd3);

    // 3: XOR F, unlimited; then disable
    arm(2'd2, 4'hF, 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) send(34'h0_1000_0000, 1'b0, 34'h0_E000_0000);
    drain();
    chk("t3_active", 64'(active), 64'd1);
    chk("t3_inj_cnt", 64'(inj_cnt), 64'd5);
    cfg_en = 1'b0;
    send(34'h0_1000_0000, 1'b0, 34'h0_1000_0000);
    chk("t3_idle", 64'(active), 64'd0);
    cfg_en = 1'b1;
    send(34'h0_1000_0000, 1'b0, 34'h0_1000_0000);
    drain();
    chk("t3_inj_hold", 64'(inj_cnt), 64'd5);

    // 4: drop, skip 1, count 2
    arm(2'd3, 4'h0, 16'd1, 16'd2);
    send(34'h0_0000_00AA, 1'b0, 34'h0_0000_00AA);
    send(34'h0_0000_00BB, 1'b1, 34'h0);
    send(34'h0_0000_00CC, 1'b1, 34'h0);
    send(34'h0_0000_00DD, 1'b0, 34'h0_0000_00DD);
    drain();
    chk("t4_inj_cnt", 64'(inj_cnt), 64'd2);
    chk("t4_done", 64'(done), 64'd1);

    // 5: force field=5, count 4, out_ready 1,0,0,1 pattern
    arm(2'd1, 4'h5, 16'd0, 16'd4);
    pat = 4'b1001;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(34'h0_0000_0100 + 34'(i), 1'b0,
               (i < 4) ? (34'h0_5000_0100 + 34'(i)) : (34'h0_0000_0100 + 34'(i)));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_inj_cnt", 64'(inj_cnt), 64'd4);
    chk("t5_done", 64'(done), 64'd1);

    // 6: reset in INJECT with a stalled word
    arm(2'd1, 4'h9, 16'd0, 16'd0);
    send(34'h0_0000_0001, 1'b0, 34'h0_9000_0001);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(34'h0_0000_0002, 1'b0, 34'h0_9000_0002);
    chk("t6_held_valid", 64'(out_valid), 64'd1);
    chk("t6_inject", 64'(active), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    out_ready = 1'b1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_active", 64'(active), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_inj", 64'(inj_cnt), 64'd0);

    // 6b: arm while in WAIT must not reload skip
    arm(2'd1, 4'h2, 16'd2, 16'd1);
    send(34'h0_0000_0010, 1'b0, 34'h0_0000_0010);
    cfg_skip = 16'd5; cfg_arm = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0; cfg_skip = '0;
    send(34'h0_0000_0011, 1'b0, 34'h0_0000_0011);
    send(34'h0_0000_0012, 1'b0, 34'h0_2000_0012);
    drain();
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_inj", 64'(inj_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
